// File: rtl/control_unit_pipelined_if.sv
// control_unit_pipelined_if: bus between fetch/hazard/datapath and the pipelined control unit
interface control_unit_pipelined_if;
   logic [31:0] InstrD;
   logic        ValidD;
   logic        StallE;
   logic        FlushE;
   logic        BranchTakenE;
   logic [2:0]  ImmSrcD;
   logic        RegWriteE;
   logic        RegWriteM;
   logic        RegWriteW;
   logic [1:0]  ResultSrcE;
   logic [1:0]  ResultSrcM;
   logic [1:0]  ResultSrcW;
   logic        MemWriteE;
   logic        MemWriteM;
   logic        ALUSrcAE;
   logic [1:0]  ALUSrcBE;
   logic [4:0]  ALUControlE;
   logic        PCSrcE;
   logic        IllegalE;
   logic        MdBusyE;
   logic        StallReq;
   modport master (
      output InstrD, ValidD, StallE, FlushE, BranchTakenE,
      input  ImmSrcD, RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, ResultSrcW,
             MemWriteE, MemWriteM, ALUSrcAE, ALUSrcBE, ALUControlE, PCSrcE, IllegalE, MdBusyE, StallReq
   );
   modport slave (
      input  InstrD, ValidD, StallE, FlushE, BranchTakenE,
      output ImmSrcD, RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, ResultSrcW,
             MemWriteE, MemWriteM, ALUSrcAE, ALUSrcBE, ALUControlE, PCSrcE, IllegalE, MdBusyE, StallReq
   );
endinterface

// File: rtl/control_unit_pipelined.sv
// control_unit_pipelined: RV32I/M decode carried through E/M/W with MUL/DIV occupancy stall
module control_unit_pipelined #(
   parameter bit EN_MEXT      = 1'b1,
   parameter int MDIV_LATENCY = 4,
   parameter int CNT_W        = 4
) (
   input logic clk,
   input logic rst,
   control_unit_pipelined_if.slave bus
);
   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [4:0] alu_ctrl;
      logic       illegal;
      logic       md;
   } e_t;
   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
   } m_t;
   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
   } w_t;
   logic [6:0] op;
   logic [6:0] f7;
   logic [2:0] f3;
   e_t dec;
   e_t e;
   m_t m;
   w_t w;
   logic [CNT_W-1:0] cnt;
   logic stall_req;
   assign op = bus.InstrD[6:0];
   assign f3 = bus.InstrD[14:12];
   assign f7 = bus.InstrD[31:25];
   function automatic logic [4:0] alu_map(input logic [2:0] f, input logic alt);
      case (f)
         3'b000:  return alt ? 5'b00001 : 5'b00000;
         3'b001:  return 5'b00111;
         3'b010:  return 5'b00101;
         3'b011:  return 5'b00110;
         3'b100:  return 5'b00100;
         3'b101:  return alt ? 5'b01001 : 5'b01000;
         3'b110:  return 5'b00011;
         default: return 5'b00010;
      endcase
   endfunction
   // Decode the D-stage instruction into a control bundle and immediate type
   always_comb begin
      dec = '0;
      bus.ImmSrcD = 3'b000;
      case (op)
         7'b0110011: begin
            if (f7 == 7'b0000001) begin
               dec.illegal   = !EN_MEXT;
               dec.md        = EN_MEXT;
               dec.reg_write = EN_MEXT;
               dec.alu_ctrl  = EN_MEXT ? {2'b10, f3} : 5'b00000;
            end else begin
               dec.reg_write = 1'b1;
               dec.alu_ctrl  = alu_map(f3, f7[5]);
            end
         end
         7'b0010011: begin
            dec.reg_write = 1'b1;
            dec.alu_src_b = 2'b01;
            dec.alu_ctrl  = alu_map(f3, (f3 == 3'b101) & f7[5]);
         end
         7'b0000011: begin
            dec.reg_write  = 1'b1;
            dec.result_src = 2'b01;
            dec.alu_src_b  = 2'b01;
         end
         7'b0100011: begin
            dec.mem_write = 1'b1;
            dec.alu_src_b = 2'b01;
            bus.ImmSrcD   = 3'b001;
         end
         7'b1100011: begin
            dec.branch   = 1'b1;
            dec.alu_ctrl = 5'b00001;
            bus.ImmSrcD  = 3'b010;
         end
         7'b1101111: begin
            dec.reg_write  = 1'b1;
            dec.jump       = 1'b1;
            dec.result_src = 2'b10;
            dec.alu_src_a  = 1'b1;
            dec.alu_src_b  = 2'b01;
            bus.ImmSrcD    = 3'b011;
         end
         7'b1100111: begin
            dec.reg_write  = 1'b1;
            dec.jump       = 1'b1;
            dec.result_src = 2'b10;
            dec.alu_src_b  = 2'b01;
         end
         7'b0110111: begin
            dec.reg_write = 1'b1;
            dec.alu_src_b = 2'b01;
            dec.alu_ctrl  = 5'b01010;
            bus.ImmSrcD   = 3'b100;
         end
         7'b0010111: begin
            dec.reg_write = 1'b1;
            dec.alu_src_a = 1'b1;
            dec.alu_src_b = 2'b01;
            bus.ImmSrcD   = 3'b100;
         end
         default: dec.illegal = 1'b1;
      endcase
   end
   assign stall_req = e.md & (cnt != '0);
   // E register: flush beats hold beats load; the counter tracks remaining MD occupancy
   always_ff @(posedge clk) begin
      if (rst || bus.FlushE) begin
         e   <= '0;
         cnt <= '0;
      end else if (bus.StallE || stall_req) begin
         cnt <= (cnt != '0) ? cnt - CNT_W'(1) : cnt;
      end else begin
         e   <= bus.ValidD ? dec : '0;
         cnt <= (bus.ValidD && dec.md) ? CNT_W'(MDIV_LATENCY - 1) : '0;
      end
   end
   // M and W always advance; M takes a bubble while an MD op holds E
   always_ff @(posedge clk) begin
      if (rst) begin
         m <= '0;
         w <= '0;
      end else begin
         m <= stall_req ? '0 : {e.reg_write, e.result_src, e.mem_write};
         w <= {m.reg_write, m.result_src};
      end
   end
   assign bus.RegWriteE   = e.reg_write;
   assign bus.ResultSrcE  = e.result_src;
   assign bus.MemWriteE   = e.mem_write;
   assign bus.ALUSrcAE    = e.alu_src_a;
   assign bus.ALUSrcBE    = e.alu_src_b;
   assign bus.ALUControlE = e.alu_ctrl;
   assign bus.IllegalE    = e.illegal;
   assign bus.MdBusyE     = e.md;
   assign bus.PCSrcE      = e.jump | (e.branch & bus.BranchTakenE);
   assign bus.StallReq    = stall_req;
   assign bus.RegWriteM   = m.reg_write;
   assign bus.ResultSrcM  = m.result_src;
   assign bus.MemWriteM   = m.mem_write;
   assign bus.RegWriteW   = w.reg_write;
   assign bus.ResultSrcW  = w.result_src;
endmodule
